// File: rtl/score_tally.sv
// Score tally display stage: counts the shown BCD score up toward the sampled result, drives 4 seven-segment digits.
// Optional HIGH_SCORE_EN adds the session high score register and the new-high blink/blank logic.

module seg7_dec (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    if (!blank) begin
      unique case (bcd)
        4'd0: seg = 7'h40;
        4'd1: seg = 7'h79;
        4'd2: seg = 7'h24;
        4'd3: seg = 7'h30;
        4'd4: seg = 7'h19;
        4'd5: seg = 7'h12;
        4'd6: seg = 7'h02;
        4'd7: seg = 7'h78;
        4'd8: seg = 7'h00;
        4'd9: seg = 7'h10;
        default: seg = 7'h7F;
      endcase
    end
  end
endmodule

module score_tally #(
  parameter int TICK_CYCLES = 500000,
  parameter int BLINK_TICKS = 50
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        game_start,
  input  logic [15:0] result,
  output logic [15:0] disp_value,
  output logic [15:0] high_score,
  output logic        busy,
  output logic        new_high,
  output logic        bcd_err,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);
  localparam int NUM_DIG = 4;
  localparam int CW = $clog2(TICK_CYCLES);

  typedef enum logic [1:0] {IDLE, TALLY, DONE} state_t;

  state_t               state, state_nxt;
  logic [15:0]          target, disp_nxt, disp_inc;
  logic [CW-1:0]        cnt;
  logic                 tick, sample_ok, blank;
  logic [NUM_DIG-1:0][6:0] hex_seg;

  function automatic logic bcd_ok(input logic [15:0] v);
    bcd_ok = 1'b1;
    for (int i = 0; i < NUM_DIG; i++)
      if (v[i*4 +: 4] > 4'd9) bcd_ok = 1'b0;
  endfunction

  // Ripple the +1 carry through the nibbles; 9 rolls to 0 and carries on.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic carry;
    carry   = 1'b1;
    bcd_inc = v;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) bcd_inc[i*4 +: 4] = 4'd0;
        else begin
          bcd_inc[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  endfunction

  assign sample_ok = bcd_ok(result);
  assign disp_inc  = bcd_inc(disp_value);
  assign tick      = (cnt == CW'(TICK_CYCLES - 1));
  assign busy      = (state == TALLY);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      target  <= '0;
      bcd_err <= 1'b0;
      cnt     <= '0;
    end else if (game_start) begin
      target  <= '0;
      bcd_err <= 1'b0;
      cnt     <= '0;
    end else begin
      if (sample_ok) target <= result;
      else           bcd_err <= 1'b1;
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      disp_value <= '0;
    end else begin
      state      <= state_nxt;
      disp_value <= disp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    disp_nxt  = disp_value;
    unique case (state)
      IDLE: begin
        if (target > disp_value)      state_nxt = TALLY;
        else if (target < disp_value) disp_nxt  = target;
      end
      TALLY: begin
        if (target < disp_value) begin
          disp_nxt  = target;
          state_nxt = IDLE;
        end else if (tick) begin
          disp_nxt = disp_inc;
          if (disp_inc == target) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (game_start) begin
      state_nxt = IDLE;
      disp_nxt  = '0;
    end
  end

`ifdef HIGH_SCORE_EN
  localparam int BW = $clog2(BLINK_TICKS + 1);
  logic [BW-1:0] bcnt;
  logic          phase;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      high_score <= '0;
      new_high   <= 1'b0;
      phase      <= 1'b0;
      bcnt       <= '0;
    end else if (game_start) begin
      new_high <= 1'b0;
      phase    <= 1'b0;
      bcnt     <= '0;
    end else if (state == DONE && target > high_score) begin
      high_score <= target;
      new_high   <= 1'b1;
      phase      <= 1'b0;
      bcnt       <= '0;
    end else if (new_high && tick) begin
      if (bcnt == BW'(BLINK_TICKS - 1)) begin
        new_high <= 1'b0;
        phase    <= 1'b0;
        bcnt     <= '0;
      end else begin
        bcnt  <= bcnt + 1'b1;
        phase <= ~phase;
      end
    end
  end

  assign blank = new_high & phase;
`else
  logic unused_cfg;
  assign unused_cfg = ^BLINK_TICKS;
  assign high_score = '0;
  assign new_high   = 1'b0;
  assign blank      = 1'b0;
`endif

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    seg7_dec u_dec (.bcd(disp_value[g*4 +: 4]), .blank(blank), .seg(hex_seg[g]));
  end

  assign HEX0 = hex_seg[0];
  assign HEX1 = hex_seg[1];
  assign HEX2 = hex_seg[2];
  assign HEX3 = hex_seg[3];
endmodule

// File: tb/tb_score_tally.sv
// Self-checking bench for score_tally: decimal-arithmetic reference model, directed scenarios plus random results.
module tb_score_tally;
  localparam int T  = 4;
  localparam int BT = 2;
`ifdef HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic        Clk = 1'b0, Reset_n = 1'b0, game_start = 1'b0;
  logic [15:0] result = '0;
  logic [15:0] disp_value, high_score;
  logic        busy, new_high, bcd_err;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  int total = 0, bad = 0;

  score_tally #(.TICK_CYCLES(T), .BLINK_TICKS(BT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .game_start(game_start), .result(result),
    .disp_value(disp_value), .high_score(high_score), .busy(busy),
    .new_high(new_high), .bcd_err(bcd_err),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3));

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [15:0] v);
    return v[15:12]*1000 + v[11:8]*100 + v[7:4]*10 + v[3:0];
  endfunction

  function automatic logic [15:0] tobcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  function automatic bit valid(input logic [15:0] v);
    return v[15:12] < 10 && v[11:8] < 10 && v[7:4] < 10 && v[3:0] < 10;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  // Reference model: mode 0 = showing target, 1 = counting up, 2 = one-cycle finish.
  logic [15:0] m_target, m_disp, m_high;
  bit m_err, m_nh, m_phase;
  int m_cyc, m_nticks, m_mode;

  task automatic model_reset();
    m_target = 0; m_disp = 0; m_high = 0; m_err = 0; m_nh = 0; m_phase = 0;
    m_cyc = 0; m_nticks = 0; m_mode = 0;
  endtask

  task automatic model_step();
    bit tk, set_now;
    logic [15:0] t, d, nd;
    int mode;
    if (!Reset_n) begin model_reset(); return; end
    if (game_start) begin
      m_target = 0; m_disp = 0; m_err = 0; m_cyc = 0; m_mode = 0;
      m_nh = 0; m_phase = 0; m_nticks = 0;
      return;
    end
    tk = (m_cyc == T-1);
    t = m_target; d = m_disp; mode = m_mode; set_now = 0;
    if (valid(result)) m_target = result; else m_err = 1;
    case (mode)
      0: if (dec(t) > dec(d)) m_mode = 1; else if (dec(t) < dec(d)) m_disp = t;
      1: if (dec(t) < dec(d)) begin m_disp = t; m_mode = 0; end
         else if (tk) begin
           nd = tobcd((dec(d) + 1) % 10000);
           m_disp = nd;
           if (nd == t) m_mode = 2;
         end
      default: begin
        m_mode = 0;
        if (HS && dec(t) > dec(m_high)) begin
          m_high = t; m_nh = 1; m_nticks = 0; m_phase = 0; set_now = 1;
        end
      end
    endcase
    if (!set_now && m_nh && tk) begin
      m_nticks++;
      if (m_nticks == BT) begin m_nh = 0; m_phase = 0; end
      else m_phase = !m_phase;
    end
    m_cyc = tk ? 0 : m_cyc + 1;
  endtask

  // Compare process: advance the model on each rising edge, check all outputs just after it.
  initial begin
    logic [6:0] eh [4];
    model_reset();
    forever begin
      @(posedge Clk);
      model_step();
      #1;
      for (int i = 0; i < 4; i++) eh[i] = (m_nh && m_phase) ? 7'h7F : seg(m_disp[i*4 +: 4]);
      check("disp_value", disp_value, m_disp);
      check("high_score", high_score, m_high);
      check("busy", busy, m_mode == 1);
      check("new_high", new_high, m_nh);
      check("bcd_err", bcd_err, m_err);
      check("HEX0", HEX0, eh[0]);
      check("HEX1", HEX1, eh[1]);
      check("HEX2", HEX2, eh[2]);
      check("HEX3", HEX3, eh[3]);
    end
  end

  task automatic wait_busy(input logic lvl, input int budget);
    int n = 0;
    while (busy !== lvl && n < budget) begin @(negedge Clk); n++; end
    if (busy !== lvl) check("wait_busy_timeout", busy, lvl);
  endtask

  task automatic wait_disp(input logic [15:0] v, input int budget);
    int n = 0;
    while (disp_value !== v && n < budget) begin @(negedge Clk); n++; end
    if (disp_value !== v) check("wait_disp_timeout", disp_value, v);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_disp"}, disp_value, 16'h0000);
    check({tag, "_high"}, high_score, 16'h0000);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_nh"}, new_high, 1'b0);
    check({tag, "_err"}, bcd_err, 1'b0);
    check({tag, "_hex"}, {HEX3, HEX2, HEX1, HEX0}, {4{7'h40}});
  endtask

  initial begin
    int nh_cnt, blank_cnt, hold;
    repeat (3) @(negedge Clk);
    check_reset_vals("rst");
    Reset_n = 1'b1;

    // Count 0 -> 10 and watch the new-high blink window.
    result = 16'h0010;
    wait_busy(1'b1, 10);
    wait_busy(1'b0, 200);
    check("s1_final_disp", disp_value, 16'h0010);
    @(negedge Clk);
    check("s1_high", high_score, HS ? 16'h0010 : 16'h0000);
    nh_cnt = 0; blank_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (new_high === 1'b1) nh_cnt++;
      if (HEX0 === 7'h7F && HEX3 === 7'h7F) blank_cnt++;
      @(negedge Clk);
    end
    check("s1_nh_cycles", nh_cnt, HS ? 7 : 0);
    check("s1_blank_cycles", blank_cnt, HS ? 4 : 0);

    // game_start mid-tally.
    result = 16'h0080;
    wait_disp(16'h0035, 400);
    game_start = 1'b1; result = 16'h0000;
    @(negedge Clk);
    check("s2_disp", disp_value, 16'h0000);
    check("s2_busy", busy, 1'b0);
    check("s2_high", high_score, HS ? 16'h0010 : 16'h0000);
    game_start = 1'b0;
    @(negedge Clk);

    // BCD carry across 0009 -> 0010.
    result = 16'h0009;
    wait_busy(1'b1, 10);
    wait_busy(1'b0, 100);
    repeat (3) @(negedge Clk);
    result = 16'h0032;
    wait_disp(16'h0010, 100);
    check("s3_hex1", HEX1, 7'h79);
    check("s3_hex0", HEX0, 7'h40);
    wait_busy(1'b0, 200);

    // Drop without tallying.
    result = 16'h0040;
    wait_busy(1'b1, 10);
    wait_busy(1'b0, 200);
    repeat (3) @(negedge Clk);
    result = 16'h0020;
    @(negedge Clk);
    check("s4_hold", disp_value, 16'h0040);
    @(negedge Clk);
    check("s4_load", disp_value, 16'h0020);
    check("s4_busy", busy, 1'b0);

    // Invalid sample, then async reset mid-tally.
    result = 16'h00A0;
    @(negedge Clk);
    check("s5_err", bcd_err, 1'b1);
    repeat (3) @(negedge Clk);
    check("s5_held", disp_value, 16'h0020);
    result = 16'h0050;
    wait_busy(1'b1, 10);
    repeat (10) @(negedge Clk);
    check("s5_sticky", bcd_err, 1'b1);
    #2 Reset_n = 1'b0;
    #1 check_reset_vals("async");
    @(negedge Clk);
    result = 16'h0000;
    Reset_n = 1'b1;

    // Random results, occasional invalid samples and game_start pulses.
    for (int s = 0; s < 40; s++) begin
      int r = $urandom_range(0, 19);
      if (r == 0) begin
        game_start = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge Clk);
        game_start = 1'b0;
      end else begin
        if (r < 3)      result = {8'h00, 4'($urandom_range(0, 9)), 4'($urandom_range(10, 15))};
        else if (r < 5) result = {8'h01, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
        else            result = {8'h00, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        hold = $urandom_range(1, 120);
        repeat (hold) @(negedge Clk);
      end
    end
    repeat (5) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
